// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bus
//
// Purpose: groups the fetch unit's instruction-memory read handshake.
// Signals:
//   imem_req     request valid (fetch unit -> memory)
//   imem_addr    request address (fetch unit -> memory)
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  read data valid, in request order, one per cycle max
//   imem_rdata   read data
// Modports: master = fetch unit side, slave = memory side.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with in-order fetch queue
//
// Purpose: accepts fetch addresses from the pc stage, issues reads to
// instruction memory, and queues returned words with their PC for the
// decoder. A flush discards queued and in-flight fetches.
// Optional feature macro: FETCH_MISALIGN_EN (misaligned fetch addresses
// produce a nop entry flagged with inst_err instead of a memory read).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   fetch_pc/_vld/_rdy  address from pc stage; rdy = address accepted
//   imem                instruction memory bus (fetch_unit_if.master)
//   flush               discard all queued and in-flight fetches
//   inst_vld/_rdy       head-of-queue handshake to decoder
//   inst_out, inst_pc   instruction word and its PC at queue head
//   inst_err            head entry is a misaligned-fetch marker
module fetch_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic            fetch_pc_vld,
  output logic            fetch_pc_rdy,
  fetch_unit_if.master    imem,
  input  logic            flush,
  output logic            inst_vld,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_err,
  input  logic            inst_rdy
);
  localparam int OUT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t state;

  logic [XLEN-1:0]  q_data  [DEPTH];
  logic [XLEN-1:0]  q_pc    [DEPTH];
  logic             q_err   [DEPTH];
  logic [XLEN-1:0]  af_addr [DEPTH];

  logic [PTR_W-1:0] head, tail, af_wr, af_rd;
  logic [OUT_W-1:0] count, outstanding, drop;

  logic [OUT_W:0]   inflight;
  logic             credit, misaligned, mem_accept, mis_accept;
  logic             rsp, push, pop, bypass;
  logic [XLEN-1:0]  push_data, push_pc;
  logic             push_err;
  logic [OUT_W-1:0] count_after_pop, count_next, drop_next;
  logic [PTR_W-1:0] head_next;

  // Credit covers queued entries plus every outstanding read, stale ones
  // included, so a returning word always has a free queue slot.
  assign inflight = {1'b0, count} + {1'b0, outstanding};
  assign credit   = inflight < (OUT_W + 1)'(DEPTH);

`ifdef FETCH_MISALIGN_EN
  assign misaligned = (fetch_pc[1:0] != 2'b00);
  // The marker entry bypasses memory, so it may only enter once every
  // earlier read has returned, otherwise it would overtake them.
  assign mis_accept = fetch_pc_vld & credit & ~flush & ~rst & misaligned &
                      (outstanding == '0);
`else
  assign misaligned = 1'b0;
  assign mis_accept = 1'b0;
`endif

  assign imem.imem_req  = fetch_pc_vld & credit & ~flush & ~rst & ~misaligned;
  assign imem.imem_addr = fetch_pc;
  assign mem_accept     = imem.imem_req & imem.imem_gnt;
  assign fetch_pc_rdy   = mem_accept | mis_accept;

  assign rsp  = imem.imem_rvalid;
  assign pop  = inst_vld & inst_rdy;
  assign push = (rsp & (state == RUN) & ~flush) | mis_accept;

  assign push_data = mis_accept ? NOP : imem.imem_rdata;
  assign push_pc   = mis_accept ? fetch_pc : af_addr[af_rd];
  assign push_err  = mis_accept;

  always_comb begin
    count_after_pop = count - OUT_W'(pop);
    count_next      = count_after_pop + OUT_W'(push);
    head_next       = head + PTR_W'(pop);
    // Pushed entry becomes the head straight away when nothing else remains.
    bypass          = push & (count_after_pop == '0);
    drop_next       = drop;
    if (flush) begin
      drop_next = outstanding - OUT_W'(rsp);
    end else if (rsp && (drop != '0)) begin
      drop_next = drop - OUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      head        <= '0;
      tail        <= '0;
      af_wr       <= '0;
      af_rd       <= '0;
      inst_vld    <= 1'b0;
      inst_out    <= '0;
      inst_pc     <= '0;
      inst_err    <= 1'b0;
    end else begin
      outstanding <= outstanding + OUT_W'(mem_accept) - OUT_W'(rsp);
      if (mem_accept) af_wr <= af_wr + PTR_W'(1);
      if (rsp)        af_rd <= af_rd + PTR_W'(1);
      drop <= drop_next;

      case (state)
        RUN:     if (drop_next != '0) state <= DRAIN;
        DRAIN:   if (drop_next == '0) state <= RUN;
        default: state <= RUN;
      endcase

      if (flush) begin
        count    <= '0;
        head     <= '0;
        tail     <= '0;
        inst_vld <= 1'b0;
        inst_err <= 1'b0;
      end else begin
        count    <= count_next;
        head     <= head_next;
        if (push) tail <= tail + PTR_W'(1);
        inst_vld <= (count_next != '0);
        if (count_next != '0) begin
          inst_out <= bypass ? push_data : q_data[head_next];
          inst_pc  <= bypass ? push_pc   : q_pc[head_next];
          inst_err <= bypass ? push_err  : q_err[head_next];
        end else begin
          inst_err <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[tail] <= push_data;
      q_pc[tail]   <= push_pc;
      q_err[tail]  <= push_err;
    end
    if (mem_accept) af_addr[af_wr] <= fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(rsp && (outstanding == '0)));
      assert (!(push && (count == OUT_W'(DEPTH))));
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        fetch_pc_vld;
  logic        fetch_pc_rdy;
  logic        flush;
  logic        inst_vld;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        inst_rdy;

  fetch_unit_if #(.XLEN(32)) imem ();

  fetch_unit #(.XLEN(32), .DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_pc     (fetch_pc),
    .fetch_pc_vld (fetch_pc_vld),
    .fetch_pc_rdy (fetch_pc_rdy),
    .imem         (imem),
    .flush        (flush),
    .inst_vld     (inst_vld),
    .inst_out     (inst_out),
    .inst_pc      (inst_pc),
    .inst_err     (inst_err),
    .inst_rdy     (inst_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } pend_t;

  exp_t  sb[$];
  pend_t pend[$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  bit    rsp_auto = 1'b0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h0001_0093;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: book-keep the cycle about to end, cross the edge, then
  // optionally drive the model memory's next response.
  task automatic step();
    exp_t  e;
    pend_t p;
    #1;
    if (rst) begin
      sb.delete();
      pend.delete();
    end else begin
      if (inst_vld && inst_rdy) begin
        chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("inst_out", inst_out, e.data);
          chk("inst_pc", inst_pc, e.pc);
          chk("inst_err", 32'(inst_err), 32'(e.err));
        end
      end
      if (flush) begin
        sb.delete();
        foreach (pend[i]) pend[i].stale = 1'b1;
      end
      if (imem.imem_rvalid) begin
        chk("rsp_has_req", 32'(pend.size() != 0), 32'd1);
        if (pend.size() != 0) p = pend.pop_front();
      end
      if (imem.imem_req && imem.imem_gnt) pend.push_back('{addr: fetch_pc, stale: 1'b0});
      if (fetch_pc_rdy) begin
`ifdef FETCH_MISALIGN_EN
        if (fetch_pc[1:0] != 2'b00)
          sb.push_back('{data: 32'h0000_0013, pc: fetch_pc, err: 1'b1});
        else
`endif
          sb.push_back('{data: mem_data(fetch_pc), pc: fetch_pc, err: 1'b0});
      end
    end
    @(posedge clk);
    #2;
    if (rsp_auto) begin
      if (pend.size() != 0) begin
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = mem_data(pend[0].addr);
      end else begin
        imem.imem_rvalid = 1'b0;
      end
    end
  endtask

  task automatic give_rsp();
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata  = (pend.size() != 0) ? mem_data(pend[0].addr) : 32'h0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (sb.size() != 0 || pend.size() != 0); i++) step();
    chk("drain_done", 32'(sb.size() + pend.size()), 32'd0);
  endtask

  task automatic wait_vld(input int budget);
    for (int i = 0; i < budget && !inst_vld; i++) step();
    #1;
    chk("wait_inst_vld", 32'(inst_vld), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    fetch_pc = 32'h0;
    fetch_pc_vld = 1'b0;
    flush = 1'b0;
    inst_rdy = 1'b0;
    imem.imem_gnt = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata = 32'h0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("reset_inst_vld", 32'(inst_vld), 32'd0);
    chk("reset_inst_out", inst_out, 32'h0);
    chk("reset_inst_pc", inst_pc, 32'h0);
    chk("reset_inst_err", 32'(inst_err), 32'd0);
    chk("reset_imem_req", 32'(imem.imem_req), 32'd0);
    chk("reset_fetch_rdy", 32'(fetch_pc_rdy), 32'd0);

    // Single fetch latency: gnt N, rvalid N+1, inst_vld N+2.
    rsp_auto = 1'b0;
    inst_rdy = 1'b1;
    imem.imem_gnt = 1'b1;
    fetch_pc = 32'h0001_0000;
    fetch_pc_vld = 1'b1;
    #1;
    chk("t1_req", 32'(imem.imem_req), 32'd1);
    chk("t1_addr", imem.imem_addr, 32'h0001_0000);
    chk("t1_rdy", 32'(fetch_pc_rdy), 32'd1);
    step();
    fetch_pc_vld = 1'b0;
    give_rsp();
    #1;
    chk("t1_vld_n1", 32'(inst_vld), 32'd0);
    step();
    imem.imem_rvalid = 1'b0;
    #1;
    chk("t1_vld_n2", 32'(inst_vld), 32'd1);
    chk("t1_out", inst_out, 32'h0000_0093);
    chk("t1_pc", inst_pc, 32'h0001_0000);
    chk("t1_err", 32'(inst_err), 32'd0);
    step();
    #1;
    chk("t1_vld_after_pop", 32'(inst_vld), 32'd0);

    // Back-pressure: two accepted, third held until a pop frees credit.
    rsp_auto = 1'b1;
    inst_rdy = 1'b0;
    fetch_pc = 32'h0001_0000;
    fetch_pc_vld = 1'b1;
    #1;
    chk("t2_rdy_a", 32'(fetch_pc_rdy), 32'd1);
    step();
    fetch_pc = 32'h0001_0004;
    #1;
    chk("t2_rdy_b", 32'(fetch_pc_rdy), 32'd1);
    step();
    fetch_pc = 32'h0001_0008;
    #1;
    chk("t2_rdy_c", 32'(fetch_pc_rdy), 32'd0);
    chk("t2_req_c", 32'(imem.imem_req), 32'd0);
    step();
    step();
    #1;
    chk("t2_full_rdy", 32'(fetch_pc_rdy), 32'd0);
    chk("t2_full_req", 32'(imem.imem_req), 32'd0);
    inst_rdy = 1'b1;
    #1;
    chk("t2_pop_cycle_rdy", 32'(fetch_pc_rdy), 32'd0);
    step();
    #1;
    chk("t2_after_pop_rdy", 32'(fetch_pc_rdy), 32'd1);
    step();
    fetch_pc_vld = 1'b0;
    drain(20);

    // Flush with two fetches in flight; stale data must never appear.
    rsp_auto = 1'b0;
    imem.imem_rvalid = 1'b0;
    fetch_pc = 32'h0001_0010;
    fetch_pc_vld = 1'b1;
    step();
    fetch_pc = 32'h0001_0014;
    step();
    flush = 1'b1;
    fetch_pc = 32'h0001_0100;
    #1;
    chk("t3_flush_req", 32'(imem.imem_req), 32'd0);
    chk("t3_flush_rdy", 32'(fetch_pc_rdy), 32'd0);
    step();
    flush = 1'b0;
    fetch_pc_vld = 1'b0;
    #1;
    chk("t3_vld_post_flush", 32'(inst_vld), 32'd0);
    give_rsp();
    step();
    give_rsp();
    #1;
    chk("t3_vld_stale1", 32'(inst_vld), 32'd0);
    step();
    imem.imem_rvalid = 1'b0;
    #1;
    chk("t3_vld_stale2", 32'(inst_vld), 32'd0);
    rsp_auto = 1'b1;
    fetch_pc = 32'h0001_0100;
    fetch_pc_vld = 1'b1;
    #1;
    chk("t3_new_rdy", 32'(fetch_pc_rdy), 32'd1);
    step();
    fetch_pc_vld = 1'b0;
    wait_vld(6);
    chk("t3_first_pc", inst_pc, 32'h0001_0100);
    drain(20);

    // Flush coinciding with rvalid and gnt: one stale read left to drop.
    rsp_auto = 1'b0;
    imem.imem_rvalid = 1'b0;
    fetch_pc = 32'h0001_0020;
    fetch_pc_vld = 1'b1;
    step();
    fetch_pc = 32'h0001_0024;
    step();
    flush = 1'b1;
    give_rsp();
    fetch_pc = 32'h0001_0028;
    #1;
    chk("t4_flush_rdy", 32'(fetch_pc_rdy), 32'd0);
    chk("t4_flush_req", 32'(imem.imem_req), 32'd0);
    step();
    flush = 1'b0;
    fetch_pc_vld = 1'b0;
    imem.imem_rvalid = 1'b0;
    #1;
    chk("t4_vld_post_flush", 32'(inst_vld), 32'd0);
    give_rsp();
    step();
    imem.imem_rvalid = 1'b0;
    #1;
    chk("t4_vld_stale", 32'(inst_vld), 32'd0);
    step();
    #1;
    chk("t4_vld_idle", 32'(inst_vld), 32'd0);
    rsp_auto = 1'b1;
    fetch_pc = 32'h0001_0030;
    fetch_pc_vld = 1'b1;
    #1;
    chk("t4_new_rdy", 32'(fetch_pc_rdy), 32'd1);
    step();
    fetch_pc_vld = 1'b0;
    drain(20);

    // Reset with a full queue.
    inst_rdy = 1'b0;
    rsp_auto = 1'b1;
    fetch_pc = 32'h0001_0040;
    fetch_pc_vld = 1'b1;
    step();
    fetch_pc = 32'h0001_0044;
    step();
    fetch_pc_vld = 1'b0;
    step();
    step();
    #1;
    chk("t5_full_vld", 32'(inst_vld), 32'd1);
    rst = 1'b1;
    step();
    #1;
    chk("t5_rst_vld", 32'(inst_vld), 32'd0);
    chk("t5_rst_req", 32'(imem.imem_req), 32'd0);
    chk("t5_rst_rdy", 32'(fetch_pc_rdy), 32'd0);
    rst = 1'b0;
    rsp_auto = 1'b0;
    imem.imem_rvalid = 1'b0;
    fetch_pc = 32'h0001_0050;
    fetch_pc_vld = 1'b1;
    #1;
    chk("t5_credit_a", 32'(fetch_pc_rdy), 32'd1);
    step();
    fetch_pc = 32'h0001_0054;
    #1;
    chk("t5_credit_b", 32'(fetch_pc_rdy), 32'd1);
    step();
    fetch_pc_vld = 1'b0;
    rsp_auto = 1'b1;
    inst_rdy = 1'b1;
    give_rsp();
    drain(20);

    // Misaligned fetch address.
    rsp_auto = 1'b1;
    inst_rdy = 1'b1;
    fetch_pc = 32'h0001_0002;
    fetch_pc_vld = 1'b1;
    #1;
`ifdef FETCH_MISALIGN_EN
    chk("t6_req", 32'(imem.imem_req), 32'd0);
    chk("t6_rdy", 32'(fetch_pc_rdy), 32'd1);
    step();
    fetch_pc_vld = 1'b0;
    wait_vld(6);
    chk("t6_err", 32'(inst_err), 32'd1);
    chk("t6_pc", inst_pc, 32'h0001_0002);
    chk("t6_out", inst_out, 32'h0000_0013);
`else
    chk("t6_req", 32'(imem.imem_req), 32'd1);
    chk("t6_addr", imem.imem_addr, 32'h0001_0002);
    chk("t6_rdy", 32'(fetch_pc_rdy), 32'd1);
    step();
    fetch_pc_vld = 1'b0;
    wait_vld(6);
    chk("t6_err", 32'(inst_err), 32'd0);
    chk("t6_pc", inst_pc, 32'h0001_0002);
`endif
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
